// File: rtl/instruction_fetch.sv
// Instruction fetch unit: single-outstanding bus reads feeding a 2-entry prefetch FIFO,
// with redirect flush and a DISCARD state that drains a read already in flight.
module instruction_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] busAddress,
    output logic        busReadEnable,
    input  logic        busReady,
    input  logic [31:0] busDataIn,
    output logic        instrValid,
    output logic [31:0] instrData,
    output logic [31:0] instrPC,
    input  logic        instrReady,
    input  logic        redirect,
    input  logic [31:0] redirectAddress
);

    typedef enum logic {S_REQ, S_DISCARD} state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_addr_q, fetch_addr_d;
    logic [31:0]     bus_addr_q, bus_addr_d;
    logic            bus_re_q, bus_re_d;
    entry_t [1:0]    ent_q, ent_d;
    logic [1:0]      count_q, count_d;

    logic            capture, hold, push, pop;
    logic [1:0]      slot;
    logic [31:0]     redir_aligned;

    assign redir_aligned = {redirectAddress[31:2], 2'b00};
    assign capture       = bus_re_q && busReady;
    assign hold          = bus_re_q && !busReady;
    // Redirect overrides both ends of the FIFO in the same cycle.
    assign pop           = (count_q != 2'd0) && instrReady && !redirect;
    assign push          = capture && (state_q == S_REQ) && !redirect;
    assign slot          = count_q - {1'b0, pop};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:     if (redirect && hold) state_d = S_DISCARD;
            S_DISCARD: if (busReady)         state_d = S_REQ;
            default:   state_d = S_REQ;
        endcase
    end

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        count_d      = count_q;
        ent_d        = ent_q;
        if (redirect) begin
            fetch_addr_d = redir_aligned;
            count_d      = 2'd0;
        end else begin
            if (pop) ent_d[0] = ent_q[1];
            if (push) begin
                ent_d[slot[0]] = '{word: busDataIn, pc: bus_addr_q};
                fetch_addr_d   = fetch_addr_q + 32'd4;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // A pending read freezes the bus; otherwise issue whenever the FIFO will have room.
    always_comb begin
        bus_re_d   = bus_re_q;
        bus_addr_d = bus_addr_q;
        if (!hold) begin
            bus_re_d   = (count_d != 2'd2);
            bus_addr_d = fetch_addr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_addr_q <= RESET_VECTOR;
            bus_addr_q   <= RESET_VECTOR;
            bus_re_q     <= 1'b0;
            count_q      <= 2'd0;
            ent_q        <= '0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            bus_addr_q   <= bus_addr_d;
            bus_re_q     <= bus_re_d;
            count_q      <= count_d;
            ent_q        <= ent_d;
        end
    end

    assign busAddress    = bus_addr_q;
    assign busReadEnable = bus_re_q;
    assign instrValid    = (count_q != 2'd0);
    assign instrData     = ent_q[0].word;
    assign instrPC       = ent_q[0].pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected PCs are queued as stimulus is set up
// and compared whenever the decoder side consumes a word.
module tb_instruction_fetch;

    localparam logic [31:0] RV  = 32'h0000_0100;
    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] busAddress;
    logic        busReadEnable;
    logic        busReady;
    logic [31:0] busDataIn;
    logic        instrValid;
    logic [31:0] instrData;
    logic [31:0] instrPC;
    logic        instrReady;
    logic        redirect;
    logic [31:0] redirectAddress;

    int nchk = 0;
    int nerr = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    instruction_fetch #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset),
        .busAddress(busAddress), .busReadEnable(busReadEnable),
        .busReady(busReady), .busDataIn(busDataIn),
        .instrValid(instrValid), .instrData(instrData), .instrPC(instrPC),
        .instrReady(instrReady), .redirect(redirect), .redirectAddress(redirectAddress)
    );

    always #5 clk = ~clk;

    // Memory model: every word is its address scrambled with KEY.
    assign busDataIn = busAddress ^ KEY;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        instrReady = 1'b0;
        busReady   = 1'b0;
        redirect   = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_re", busReadEnable, 0);
        chk("rst_addr", busAddress, RV);
        chk("rst_valid", instrValid, 0);
        exp_q.delete();
        step();
        reset = 1'b0;
    endtask

    // Decoder side: a word is consumed at the next edge when valid && ready and no redirect.
    always @(negedge clk) begin
        if (!reset && !redirect && instrValid && instrReady) begin
            chk("pop_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("instrPC", instrPC, e);
                chk("instrData", instrData, e ^ KEY);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset = 1'b1; busReady = 1'b0; instrReady = 1'b0;
        redirect = 1'b0; redirectAddress = '0;
        #3;
        chk("t1_re", busReadEnable, 0);
        chk("t1_addr", busAddress, RV);
        chk("t1_valid", instrValid, 0);
        chk("t1_data", instrData, 0);
        chk("t1_pc", instrPC, 0);
        step();
        chk("t1_re_hold", busReadEnable, 0);
        reset = 1'b0;

        // Streaming: one request per cycle, every word delivered in order.
        for (int i = 0; i < 16; i++) exp_q.push_back(RV + 32'(4 * i));
        busReady = 1'b1; instrReady = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            step();
            k++;
            chk("t2_re", busReadEnable, 1);
            chk("t2_addr", busAddress, RV + 32'(4 * (k - 1)));
            if (k >= 2) chk("t2_valid", instrValid, 1);
        end
        instrReady = 1'b0;
        chk("t2_drained", 32'(exp_q.size()), 0);

        // Backpressure: two words buffered, then one pop reopens fetch.
        do_reset();
        busReady = 1'b1;
        repeat (5) step();
        chk("t3_re", busReadEnable, 0);
        chk("t3_valid", instrValid, 1);
        chk("t3_pc", instrPC, RV);
        exp_q.push_back(RV);
        instrReady = 1'b1;
        step();
        instrReady = 1'b0;
        chk("t3_re2", busReadEnable, 1);
        chk("t3_addr2", busAddress, RV + 32'd8);
        chk("t3_pc2", instrPC, RV + 32'd4);
        chk("t3_drained", 32'(exp_q.size()), 0);

        // Slow memory: request held stable until busReady.
        do_reset();
        instrReady = 1'b1;
        step();
        chk("t4_re0", busReadEnable, 1);
        chk("t4_addr0", busAddress, RV);
        repeat (3) begin
            step();
            chk("t4_re", busReadEnable, 1);
            chk("t4_addr", busAddress, RV);
            chk("t4_valid", instrValid, 0);
        end
        busReady = 1'b1;
        exp_q.push_back(RV);
        step();
        busReady = 1'b0;
        chk("t4_valid1", instrValid, 1);
        chk("t4_addr1", busAddress, RV + 32'd4);
        step();
        chk("t4_drained", 32'(exp_q.size()), 0);
        chk("t4_valid2", instrValid, 0);

        // Redirect while a read is pending: drained word dropped, restart at aligned target.
        do_reset();
        busReady = 1'b1; instrReady = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(RV + 32'(4 * i));
        repeat (5) step();
        chk("t5_addr_p", busAddress, RV + 32'h10);
        busReady = 1'b0; redirect = 1'b1; redirectAddress = 32'h0000_0203;
        step();
        redirect = 1'b0;
        chk("t5_re_d", busReadEnable, 1);
        chk("t5_addr_d", busAddress, RV + 32'h10);
        chk("t5_valid_d", instrValid, 0);
        step();
        chk("t5_addr_d2", busAddress, RV + 32'h10);
        chk("t5_valid_d2", instrValid, 0);
        busReady = 1'b1;
        exp_q.push_back(32'h0000_0200);
        step();
        chk("t5_addr_n", busAddress, 32'h0000_0200);
        chk("t5_re_n", busReadEnable, 1);
        chk("t5_valid_n", instrValid, 0);
        step();
        chk("t5_valid", instrValid, 1);
        chk("t5_pc", instrPC, 32'h0000_0200);
        chk("t5_addr_n2", busAddress, 32'h0000_0204);
        busReady = 1'b0;
        step();
        instrReady = 1'b0;
        chk("t5_drained", 32'(exp_q.size()), 0);

        // Redirect with full FIFO, pop and busReady all in the same cycle.
        do_reset();
        busReady = 1'b1;
        repeat (4) step();
        chk("t6_re_full", busReadEnable, 0);
        chk("t6_valid_full", instrValid, 1);
        instrReady = 1'b1; redirect = 1'b1; redirectAddress = 32'h0000_0080;
        step();
        redirect = 1'b0;
        chk("t6_valid", instrValid, 0);
        chk("t6_re", busReadEnable, 1);
        chk("t6_addr", busAddress, 32'h0000_0080);
        exp_q.push_back(32'h0000_0080);
        step();
        chk("t6_pc", instrPC, 32'h0000_0080);
        busReady = 1'b0;
        step();
        instrReady = 1'b0;
        chk("t6_drained", 32'(exp_q.size()), 0);

        // Redirect on the busReady edge, address wrap, then reset mid-wait.
        do_reset();
        instrReady = 1'b1;
        step();
        chk("t7_addr0", busAddress, RV);
        busReady = 1'b1; redirect = 1'b1; redirectAddress = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        chk("t7_addr_top", busAddress, 32'hFFFF_FFFC);
        chk("t7_valid0", instrValid, 0);
        exp_q.push_back(32'hFFFF_FFFC);
        step();
        chk("t7_addr_wrap", busAddress, 32'h0000_0000);
        chk("t7_pc_top", instrPC, 32'hFFFF_FFFC);
        busReady = 1'b0;
        step();
        chk("t7_re_wait", busReadEnable, 1);
        chk("t7_drained", 32'(exp_q.size()), 0);
        instrReady = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("t7_rst_re", busReadEnable, 0);
        chk("t7_rst_addr", busAddress, RV);
        chk("t7_rst_valid", instrValid, 0);
        chk("t7_rst_data", instrData, 0);
        busReady = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("t7_re_new", busReadEnable, 1);
        chk("t7_addr_new", busAddress, RV);
        chk("t7_valid_new", instrValid, 0);
        step();
        chk("t7_valid_cap", instrValid, 1);
        chk("t7_pc_cap", instrPC, RV);
        chk("t7_data_cap", instrData, RV ^ KEY);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h00000000: first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 busAddress  output  32  fetch address; bits [1:0] always 0.
REQ-005 busReadEnable  output  1  read request; held high until busReady sampled high.
REQ-006 busReady  input  1  memory asserts when busDataIn is valid for the pending read.
REQ-007 busDataIn  input  32  instruction word returned by memory.
REQ-008 instrValid  output  1  head entry of prefetch buffer is valid.
REQ-009 instrData  output  32  head instruction word.
REQ-010 instrPC  output  32  address the head word was fetched from.
REQ-011 instrReady  input  1  decoder consumes head entry when instrValid && instrReady.
REQ-012 redirect  input  1  one-cycle pulse: flush and restart fetch (jump/branch taken).
REQ-013 redirectAddress  input  32  new fetch address; bits [1:0] ignored and forced to 0.

Function
REQ-014 Internal state: fetchAddr register, 2-entry FIFO of {word, pc}, FSM states REQ (transaction may be issued/pending) and DISCARD (pending transaction completes, data dropped).
REQ-015 Bus transaction: busReadEnable and busAddress registered, held stable from assertion until the edge where busReady is sampled high; data captured at that edge; at most one transaction outstanding.
REQ-016 busReadEnable rises/stays high at an edge only if FIFO occupancy after that edge's push/pop is < 2 (transactions may run back-to-back with no idle cycle).
REQ-017 On capture in REQ: push {busDataIn, busAddress}; fetchAddr increments by 4 modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-018 instrValid = FIFO not empty; instrData/instrPC show head entry; outputs registered, data appears the cycle after capture (1-cycle latency).
REQ-019 Simultaneous push and pop with FIFO full or non-empty: occupancy unchanged, order preserved.
REQ-020 FIFO full (2): no new request; busReadEnable low until a pop occurs.
REQ-021 redirect (highest priority, overrides push and pop same cycle): FIFO emptied (instrValid low next cycle), fetchAddr <= {redirectAddress[31:2], 2'b00}.
REQ-022 redirect with transaction pending and busReady low: enter DISCARD; busReadEnable/busAddress held on old values until busReady; that word dropped; next edge issues request at redirect address, return to REQ.
REQ-023 redirect coinciding with busReady high: word dropped, new request issued at next edge at redirect address, stay in REQ.
REQ-024 redirect while in DISCARD: fetchAddr updated to latest redirectAddress; remain DISCARD.
REQ-025 redirect with no pending transaction: request at redirect address issued at the next edge.
REQ-026 instrReady while instrValid low: no effect.

Reset
REQ-027 reset asserted: immediately busReadEnable=0, busAddress=RESET_VECTOR, instrValid=0, instrData=0, instrPC=0, FIFO empty, fetchAddr=RESET_VECTOR, FSM=REQ.
REQ-028 First rising edge after reset deassertion: busReadEnable=1, busAddress=RESET_VECTOR.
REQ-029 reset mid-transaction: transaction abandoned; any later busReady before the new request ignored.

Verification
REQ-030 Reset, busReady tied high, instrReady high, busDataIn=addr^32'hA5A5A5A5 -> busAddress 0,4,8,... one per cycle; instrValid steady 1; instrPC/instrData match in order, none lost/duplicated.
REQ-031 instrReady low, busReady high -> exactly 2 words (pc 0,4) buffered, busReadEnable low; instrReady high one cycle -> pc 0 popped, request at 8 issued next edge.
REQ-032 busReady delayed 3 cycles -> busAddress and busReadEnable stable all 3 cycles; word captured only on busReady edge.
REQ-033 Request pending at 0x10, redirect to 0x203 with busReady low 2 more cycles -> word from 0x10 dropped, instrValid 0, next request at 0x200, first delivered instrPC=0x200.
REQ-034 redirect same cycle as busReady and pop with FIFO full -> FIFO empty next cycle, request at redirect address next edge.
REQ-035 redirect to 0xFFFFFFFC, busReady high -> busAddress 0xFFFFFFFC then 0x00000000; reset asserted mid-wait -> busReadEnable 0 immediately, resumes at RESET_VECTOR.
